// File: rtl/poly_arith_pkg.sv
// poly_arith_pkg: shared widths, coefficient types and skid-buffer states for the polynomial datapath
package poly_arith_pkg;
    localparam int DWIDTH = 256;
    localparam int KEEP_WIDTH = 32;
    localparam int COEFFS_PER_BEAT = 16;
    localparam int BEATS_PER_POLY = 16;
    localparam int COEFF_WIDTH = 12;
    localparam logic [15:0] Q = 16'd3329;
    typedef logic [COEFF_WIDTH-1:0] coeff_t;
    typedef logic [$clog2(BEATS_PER_POLY)-1:0] beat_idx_t;
    typedef coeff_t [COEFFS_PER_BEAT-1:0] coeff_beat_t;
    localparam beat_idx_t LAST_BEAT_IDX = beat_idx_t'(BEATS_PER_POLY - 1);
    typedef struct packed {
        coeff_beat_t coeff;
        beat_idx_t beat_idx;
        logic last;
    } unpack_beat_t;
    typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_t;
endpackage

// File: rtl/poly_axis_unpacker_if.sv
// poly_axis_unpacker_if: host-side AXI4-Stream bundle and PE-side coefficient bundle
//   poly_axis_if  : tdata, tkeep, tvalid, tlast (master drives), tready (slave drives)
//   poly_coeff_if : coeff, beat_idx, last, valid (master drives), ready (slave drives)
interface poly_axis_if;
    import poly_arith_pkg::*;
    logic [DWIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic tvalid;
    logic tlast;
    logic tready;
    modport master(output tdata, tkeep, tvalid, tlast, input tready);
    modport slave(input tdata, tkeep, tvalid, tlast, output tready);
endinterface

interface poly_coeff_if;
    import poly_arith_pkg::*;
    coeff_beat_t coeff;
    beat_idx_t beat_idx;
    logic last;
    logic valid;
    logic ready;
    modport master(output coeff, beat_idx, last, valid, input ready);
    modport slave(input coeff, beat_idx, last, valid, output ready);
endinterface

// File: rtl/poly_axis_unpacker_skid.sv
// poly_skid_buffer: 2-entry valid/ready skid buffer, payload width WIDTH
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/valid/ready  : upstream side; in_ready is registered (high unless full)
//   out_data/valid/ready : downstream side; out_data is always the oldest entry
module poly_skid_buffer
    import poly_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    skid_state_t state;
    logic [WIDTH-1:0] tail;
    logic push, pop;

    assign push = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // out_data is the head register; tail only holds the second entry while FULL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SKID_EMPTY;
            in_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            tail <= '0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    in_ready <= 1'b1;
                    if (push) begin
                        out_data <= in_data;
                        out_valid <= 1'b1;
                        state <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push && pop) begin
                        out_data <= in_data;
                    end else if (push) begin
                        tail <= in_data;
                        in_ready <= 1'b0;
                        state <= SKID_FULL;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        out_data <= tail;
                        in_ready <= 1'b1;
                        state <= SKID_ONE;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                    out_valid <= 1'b0;
                    state <= SKID_EMPTY;
                end
            endcase
        end
    end
endmodule

// File: rtl/poly_axis_unpacker.sv
// poly_axis_unpacker: AXI4-Stream ingress that range-checks, frames and unpacks 16 coefficients per beat
//   clk, rst_n   : clock, asynchronous active-low reset
//   s_axis       : 256-bit host stream (16 lanes of 16-bit stored coefficients)
//   m            : 16 x coeff_t per beat with beat index and last flag, valid/ready
//   poly_done    : one-cycle pulse after the m.last output handshake
//   err_range    : sticky, a lane was out of range
//   err_framing  : sticky, TLAST/TKEEP framing violation
//   err_clr      : synchronous clear of both sticky flags (a new error in the same cycle wins)
// Build option: POLY_UNPACK_REDUCE_EN subtracts Q from lanes in [Q, 4095] instead of flagging them.
module poly_axis_unpacker
    import poly_arith_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    poly_axis_if.slave   s_axis,
    poly_coeff_if.master m,
    output logic         poly_done,
    output logic         err_range,
    output logic         err_framing,
    input  logic         err_clr
);
    beat_idx_t cnt;
    coeff_beat_t lane_coeff;
    logic [COEFFS_PER_BEAT-1:0] lane_bad;
    logic in_ready, accept, last_beat, frame_bad;
    unpack_beat_t in_beat, out_beat;

    genvar i;
    for (i = 0; i < COEFFS_PER_BEAT; i++) begin : g_lane
        logic [15:0] raw;
        assign raw = s_axis.tdata[16*i +: 16];
`ifdef POLY_UNPACK_REDUCE_EN
        logic fixable;
        assign fixable = (raw[15:12] == 4'd0) && (raw >= Q);
        assign lane_coeff[i] = fixable ? coeff_t'(raw - Q) : raw[11:0];
        assign lane_bad[i] = |raw[15:12];
`else
        assign lane_coeff[i] = raw[11:0];
        assign lane_bad[i] = raw >= Q;
`endif
    end

    assign s_axis.tready = in_ready;
    assign accept = s_axis.tvalid & in_ready;
    // a beat is last on TLAST or when the counter wraps; any disagreement between the two is a framing error
    assign last_beat = s_axis.tlast | (cnt == LAST_BEAT_IDX);
    assign frame_bad = (s_axis.tlast != (cnt == LAST_BEAT_IDX)) | ~&s_axis.tkeep;
    assign in_beat = '{coeff: lane_coeff, beat_idx: cnt, last: last_beat};

    poly_skid_buffer #(
        .WIDTH($bits(unpack_beat_t))
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_beat),
        .in_valid (s_axis.tvalid),
        .in_ready (in_ready),
        .out_data (out_beat),
        .out_valid(m.valid),
        .out_ready(m.ready)
    );

    assign m.coeff = out_beat.coeff;
    assign m.beat_idx = out_beat.beat_idx;
    assign m.last = out_beat.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            poly_done <= 1'b0;
            err_range <= 1'b0;
            err_framing <= 1'b0;
        end else begin
            if (accept) cnt <= last_beat ? '0 : cnt + 1'b1;
            poly_done <= m.valid & m.ready & m.last;
            err_range <= (err_range & ~err_clr) | (accept & |lane_bad);
            err_framing <= (err_framing & ~err_clr) | (accept & frame_bad);
        end
    end
endmodule
